seg_disp_sched: RTL and testbench
=================================

Name: seg_disp_sched

Overview:
Display scheduler that sits in front of the six-digit seg_dynamic/hc595 display path and drives its data/point/sign/seg_en inputs. It shares the single display between a continuous background source (e.g. a live counter) and a one-shot message source. A message preempts the background for a fixed hold time, optionally blinking, then the display reverts automatically. All values are clamped to the displayable range.

Parameters:
TICK_MAX, 50000, sys_clk cycles per 1 ms tick (50 MHz clock)
HOLD_MS, 2000, message hold time in ticks
BLINK_MS, 250, blink half-period in ticks (seg_en on/off interval)

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous reset, active low
bg_data  in  20  background value, unsigned
bg_point  in  6  background decimal-point mask
bg_sign  in  1  background minus-sign flag
bg_en  in  1  background display enable
msg_req  in  1  message request; rising edge triggers
msg_data  in  20  message value, sampled on accept
msg_point  in  6  message point mask, sampled on accept
msg_sign  in  1  message sign, sampled on accept
msg_blink  in  1  blink message, sampled on accept
msg_cancel  in  1  abort current message
msg_ack  out  1  one-cycle pulse, message accepted
msg_busy  out  1  high while message is displayed
data  out  20  to display data input
point  out  6  to display point input
sign  out  1  to display sign input
seg_en  out  1  to display enable input
src  out  1  0 = background, 1 = message

Behaviour:
- Reset (async, sys_rst_n=0): state BG; data=0, point=0, sign=0, seg_en=0, src=0, msg_ack=0, msg_busy=0; all counters 0; message registers 0; msg_req edge register 0. Reset during MSG discards the message.
- Request edge: req_d is msg_req registered. A request is accepted at edge N if msg_req=1 at N and req_d=0 (it was 0 at N-1). A held-high msg_req gives no further accepts.
- On accept at edge N: latch msg_data (clamped), msg_point, msg_sign, msg_blink; state<=MSG; tick and hold counters <=0; blink phase <=on. msg_ack=1 for cycle N..N+1 only.
- Accept in MSG (preempt): same actions, so the new message replaces the old one and the hold restarts.
- Clamp: a value >999_999 is replaced by 999_999, for both msg_data and bg_data.
- Tick: counter 0..TICK_MAX-1; tick pulse when it equals TICK_MAX-1. It is free-running in BG and cleared on accept.
- Hold: in MSG, the hold counter increments on each tick. When the tick occurs with hold=HOLD_MS-1, state<=BG. The message is visible for exactly HOLD_MS*TICK_MAX cycles.
- Blink: when msg_blink is latched, the phase toggles every BLINK_MS ticks, starting on.
- Cancel: msg_cancel=1 in MSG gives state<=BG at the next edge. Cancel and accept at the same edge: the accept wins. Cancel in BG is ignored.
- Outputs are registered, one cycle after state/registers:
  - BG: data=clamp(bg_data), point=bg_point, sign=bg_sign, seg_en=bg_en, src=0, msg_busy=0. Background inputs track live, with 1-cycle latency.
  - MSG: data/point/sign from the latched message, src=1, msg_busy=1. seg_en=1 if not blinking, else the blink phase. bg_en is ignored.
- First message output cycle is N+1. First background output cycle is one cycle after the state returns to BG.
- Counters are wide enough for the parameters: tick 16 bits, hold/blink 12 bits minimum for the defaults.

Test Plan:
- Reset mid-message (TICK_MAX=4, HOLD_MS=5): assert sys_rst_n=0 during MSG -> all outputs 0 asynchronously. After release -> BG, src=0, bg values shown 1 cycle later.
- Background pass-through and clamp: bg_data=123456, bg_point=6'b000100, bg_en=1 -> data=123456, seg_en=1 next cycle. bg_data=1_000_000 -> data=999999.
- Message hold: msg_req rises with msg_data=42, msg_blink=0 -> msg_ack one pulse, data=42, src=1 for exactly 20 cycles, then bg restored. Holding msg_req high afterwards -> no second accept.
- Blink (BLINK_MS=2, TICK_MAX=4): message with msg_blink=1 -> seg_en pattern on 8 cycles, off 8, on 4, then background.
- Preempt: second rising request carrying 77 at cycle 10 of a message -> data=77, hold restarts for a full 20 cycles.
- Cancel: msg_cancel mid-message -> BG next edge. msg_cancel and a request edge in the same cycle -> new message shown, hold restarts.

Source files
------------

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: shares the six-digit display between a live background value and a timed, optionally blinking message.
module seg_disp_sched #(
  parameter int unsigned TICK_MAX = 50000,
  parameter int unsigned HOLD_MS  = 2000,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] bg_data,
  input  logic [5:0]  bg_point,
  input  logic        bg_sign,
  input  logic        bg_en,
  input  logic        msg_req,
  input  logic [19:0] msg_data,
  input  logic [5:0]  msg_point,
  input  logic        msg_sign,
  input  logic        msg_blink,
  input  logic        msg_cancel,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en,
  output logic        src
);
  localparam logic [19:0] DMAX  = 20'd999999;
  localparam logic [15:0] TLAST = 16'(TICK_MAX - 1);
  localparam logic [11:0] HLAST = 12'(HOLD_MS - 1);
  localparam logic [11:0] BLAST = 12'(BLINK_MS - 1);
  typedef enum logic {BG, MSG} state_t;
  state_t      state_q, state_d;
  logic        req_q, accept, tick;
  logic [15:0] tick_q, tick_d;
  logic [11:0] hold_q, hold_d, bcnt_q, bcnt_d;
  logic        phase_q, phase_d;
  logic [19:0] mdata_q, mdata_d, bg_clamp;
  logic [5:0]  mpoint_q, mpoint_d;
  logic        msign_q, msign_d, mblink_q, mblink_d;
  logic [19:0] data_q, data_d;
  logic [5:0]  point_q, point_d;
  logic        sign_q, sign_d, en_q, en_d, src_q, src_d, ack_q;
  assign accept   = msg_req & ~req_q;
  assign tick     = tick_q == TLAST;
  assign bg_clamp = (bg_data > DMAX) ? DMAX : bg_data;
  always_comb begin
    state_d  = state_q;
    tick_d   = tick ? '0 : tick_q + 16'd1;
    hold_d   = hold_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    mdata_d  = mdata_q;
    mpoint_d = mpoint_q;
    msign_d  = msign_q;
    mblink_d = mblink_q;
    if (state_q == MSG && tick) begin
      hold_d  = hold_q + 12'd1;
      state_d = (hold_q == HLAST) ? BG : MSG;
      bcnt_d  = (bcnt_q == BLAST) ? '0 : bcnt_q + 12'd1;
      phase_d = (bcnt_q == BLAST) ? ~phase_q : phase_q;
    end
    if (state_q == MSG && msg_cancel) state_d = BG;
    // A fresh request edge overrides both hold expiry and cancel
    if (accept) begin
      state_d  = MSG;
      tick_d   = '0;
      hold_d   = '0;
      bcnt_d   = '0;
      phase_d  = 1'b1;
      mdata_d  = (msg_data > DMAX) ? DMAX : msg_data;
      mpoint_d = msg_point;
      msign_d  = msg_sign;
      mblink_d = msg_blink;
    end
    src_d   = state_q == MSG;
    data_d  = src_d ? mdata_q : bg_clamp;
    point_d = src_d ? mpoint_q : bg_point;
    sign_d  = src_d ? msign_q : bg_sign;
    en_d    = src_d ? (~mblink_q | phase_q) : bg_en;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= BG;
      req_q    <= 1'b0;
      tick_q   <= '0;
      hold_q   <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      mdata_q  <= '0;
      mpoint_q <= '0;
      msign_q  <= 1'b0;
      mblink_q <= 1'b0;
      data_q   <= '0;
      point_q  <= '0;
      sign_q   <= 1'b0;
      en_q     <= 1'b0;
      src_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= msg_req;
      tick_q   <= tick_d;
      hold_q   <= hold_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      mdata_q  <= mdata_d;
      mpoint_q <= mpoint_d;
      msign_q  <= msign_d;
      mblink_q <= mblink_d;
      data_q   <= data_d;
      point_q  <= point_d;
      sign_q   <= sign_d;
      en_q     <= en_d;
      src_q    <= src_d;
      ack_q    <= accept;
    end
  end
  assign data     = data_q;
  assign point    = point_q;
  assign sign     = sign_q;
  assign seg_en   = en_q;
  assign src      = src_q;
  assign msg_busy = src_q;
  assign msg_ack  = ack_q;
endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: randomized and directed stimulus scored against a cycle-count model of the scheduler.
module tb_seg_disp_sched;
  localparam int T = 4, H = 5, B = 2;
  logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic [19:0] bg_data = '0, msg_data = '0;
  logic [5:0]  bg_point = '0, msg_point = '0;
  logic        bg_sign = 1'b0, bg_en = 1'b0, msg_req = 1'b0, msg_sign = 1'b0, msg_blink = 1'b0, msg_cancel = 1'b0;
  logic        msg_ack, msg_busy, sign, seg_en, src;
  logic [19:0] data;
  logic [5:0]  point;
  seg_disp_sched #(.TICK_MAX(T), .HOLD_MS(H), .BLINK_MS(B)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .bg_data(bg_data), .bg_point(bg_point), .bg_sign(bg_sign), .bg_en(bg_en),
    .msg_req(msg_req), .msg_data(msg_data), .msg_point(msg_point), .msg_sign(msg_sign),
    .msg_blink(msg_blink), .msg_cancel(msg_cancel),
    .msg_ack(msg_ack), .msg_busy(msg_busy), .data(data), .point(point),
    .sign(sign), .seg_en(seg_en), .src(src)
  );
  always #5 sys_clk = ~sys_clk;
  typedef struct packed {
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign, seg_en, src, ack, busy;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  logic        in_msg = 1'b0, prev_req = 1'b0, m_sign = 1'b0, m_blink = 1'b0;
  int          c = 0, acc = 0;
  logic [19:0] m_data = '0;
  logic [5:0]  m_point = '0;
  function automatic logic [19:0] clamp(input logic [19:0] v);
    return (v > 20'd999999) ? 20'd999999 : v;
  endfunction
  // Expected output after the next edge, then the model's own state change for that edge
  task automatic cyc();
    exp_t e;
    logic accept;
    c++;
    e.data   = in_msg ? m_data : clamp(bg_data);
    e.point  = in_msg ? m_point : bg_point;
    e.sign   = in_msg ? m_sign : bg_sign;
    e.seg_en = in_msg ? (!m_blink || (((c - acc - 1) / (B * T)) % 2 == 0)) : bg_en;
    e.src    = in_msg;
    e.busy   = in_msg;
    accept   = msg_req && !prev_req;
    prev_req = msg_req;
    e.ack    = accept;
    if (accept) begin
      in_msg  = 1'b1;
      acc     = c;
      m_data  = clamp(msg_data);
      m_point = msg_point;
      m_sign  = msg_sign;
      m_blink = msg_blink;
    end else if (in_msg && (msg_cancel || c - acc == H * T)) in_msg = 1'b0;
    q.push_back(e);
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask
  task automatic chk_zero(input string n);
    total++;
    if ({data, point, sign, seg_en, src, msg_ack, msg_busy} !== '0) begin
      bad++;
      $display("FAIL %s: got data=%0d point=%b sign=%b en=%b src=%b ack=%b busy=%b want all 0",
               n, data, point, sign, seg_en, src, msg_ack, msg_busy);
    end
  endtask
  initial begin
    exp_t e, g;
    forever begin
      @(posedge sys_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = '{data, point, sign, seg_en, src, msg_ack, msg_busy};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL out@%0d: got data=%0d point=%b sign=%b en=%b src=%b ack=%b busy=%b want data=%0d point=%b sign=%b en=%b src=%b ack=%b busy=%b",
                   c, g.data, g.point, g.sign, g.seg_en, g.src, g.ack, g.busy,
                   e.data, e.point, e.sign, e.seg_en, e.src, e.ack, e.busy);
        end
      end
    end
  end
  initial begin
    repeat (3) @(negedge sys_clk);
    chk_zero("reset");
    sys_rst_n = 1'b1;
    bg_data = 20'd123456; bg_point = 6'b000100; bg_en = 1'b1;
    cyc(); cyc();
    bg_data = 20'd1000000;
    cyc(); cyc();
    bg_sign = 1'b1;
    cyc();
    msg_data = 20'd42; msg_blink = 1'b0; msg_req = 1'b1;
    repeat (25) cyc();
    msg_req = 1'b0;
    repeat (3) cyc();
    msg_data = 20'd7; msg_blink = 1'b1; msg_req = 1'b1;
    cyc();
    msg_req = 1'b0;
    repeat (24) cyc();
    msg_data = 20'd5; msg_blink = 1'b0; msg_req = 1'b1;
    cyc();
    msg_req = 1'b0;
    repeat (9) cyc();
    msg_data = 20'd77; msg_req = 1'b1;
    cyc();
    msg_req = 1'b0;
    repeat (24) cyc();
    msg_req = 1'b1;
    cyc();
    msg_req = 1'b0;
    repeat (5) cyc();
    msg_cancel = 1'b1;
    cyc();
    msg_cancel = 1'b0;
    repeat (3) cyc();
    msg_data = 20'd1048000; msg_req = 1'b1;
    cyc();
    msg_req = 1'b0;
    repeat (5) cyc();
    msg_data = 20'd99; msg_req = 1'b1; msg_cancel = 1'b1;
    cyc();
    msg_req = 1'b0; msg_cancel = 1'b0;
    repeat (22) cyc();
    msg_data = 20'd3; msg_req = 1'b1;
    cyc();
    msg_req = 1'b0;
    repeat (3) cyc();
    sys_rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    in_msg = 1'b0; prev_req = 1'b0;
    bg_data = 20'd654321;
    repeat (3) cyc();
    repeat (2000) begin
      if ($urandom_range(0, 7) == 0) msg_req = ~msg_req;
      msg_cancel = $urandom_range(0, 15) == 0;
      msg_data   = 20'($urandom);
      msg_point  = 6'($urandom);
      msg_sign   = 1'($urandom);
      msg_blink  = 1'($urandom);
      bg_data    = 20'($urandom);
      bg_point   = 6'($urandom);
      bg_sign    = 1'($urandom);
      bg_en      = 1'($urandom);
      cyc();
    end
    @(posedge sys_clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
